// File: rtl/sipo_pkg.sv
// Shared types and constants for the SIPO receiver.
package sipo_pkg;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_SHIFT = 2'd1,
      S_STOP  = 2'd2
   } state_e;

   localparam int unsigned DEFAULT_WIDTH = 8;
   localparam int unsigned FRAME_BITS    = DEFAULT_WIDTH + 2;

   // Line bits per frame: start + data + stop.
   function automatic int unsigned frame_bits(input int unsigned width);
      return width + 2;
   endfunction

endpackage

// File: rtl/sipo_hold_reg.sv
// One-entry valid/ready holding register between the bit stream and the word consumer.
module sipo_hold_reg
   import sipo_pkg::*;
#(
   parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load,
   input  logic [WIDTH-1:0] word,
   input  logic             ready,
   output logic [WIDTH-1:0] par_out,
   output logic             par_valid,
   output logic             overrun
);

   logic [WIDTH-1:0] data_q, data_d;
   logic             valid_q, valid_d;
   logic             overrun_q, overrun_d;

   // A load is taken when the slot is empty or being drained this cycle; otherwise it overruns.
   always_comb begin
      data_d    = data_q;
      valid_d   = valid_q;
      overrun_d = 1'b0;
      if (load) begin
         if (!valid_q || ready) begin
            data_d  = word;
            valid_d = 1'b1;
         end else begin
            overrun_d = 1'b1;
         end
      end else if (valid_q && ready) begin
         valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         data_q    <= '0;
         valid_q   <= 1'b0;
         overrun_q <= 1'b0;
      end else begin
         data_q    <= data_d;
         valid_q   <= valid_d;
         overrun_q <= overrun_d;
      end
   end

   assign par_out   = data_q;
   assign par_valid = valid_q;
   assign overrun   = overrun_q;

endmodule

// File: rtl/sipo_receiver.sv
// Serial-in parallel-out receiver: start-bit hunt, WIDTH data bits, stop check, buffered word output.
module sipo_receiver
   import sipo_pkg::*;
#(
   parameter int unsigned WIDTH      = DEFAULT_WIDTH,
   parameter bit          MSB_FIRST  = 1'b1,
   parameter bit          IDLE_LEVEL = 1'b1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             ser_in,
   input  logic             ser_en,
   output logic [WIDTH-1:0] par_out,
   output logic             par_valid,
   input  logic             par_ready,
   output logic             busy,
   output logic             frame_err,
   output logic             overrun
);

   localparam int unsigned CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

   state_e           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [WIDTH-1:0] shift_q, shift_d;
   logic             frame_err_q, frame_err_d;
   logic             busy_q, busy_d;
   logic             load_c;

   // Frame FSM; everything here advances only on bit strobes.
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      shift_d     = shift_q;
      frame_err_d = 1'b0;
      load_c      = 1'b0;
      if (ser_en) begin
         case (state_q)
            S_IDLE: begin
               if (ser_in == ~IDLE_LEVEL) begin
                  state_d = S_SHIFT;
                  cnt_d   = '0;
               end
            end
            S_SHIFT: begin
               shift_d = MSB_FIRST ? {shift_q[WIDTH-2:0], ser_in}
                                   : {ser_in, shift_q[WIDTH-1:1]};
               // Counter holds on the last data bit rather than wrapping.
               if (cnt_q == CNT_W'(WIDTH - 1)) begin
                  state_d = S_STOP;
               end else begin
                  cnt_d = cnt_q + CNT_W'(1);
               end
            end
            S_STOP: begin
               state_d = S_IDLE;
               if (ser_in == IDLE_LEVEL) begin
                  load_c = 1'b1;
               end else begin
                  frame_err_d = 1'b1;
               end
            end
            default: state_d = S_IDLE;
         endcase
      end
      busy_d = (state_d != S_IDLE);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= S_IDLE;
         cnt_q       <= '0;
         shift_q     <= '0;
         frame_err_q <= 1'b0;
         busy_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         shift_q     <= shift_d;
         frame_err_q <= frame_err_d;
         busy_q      <= busy_d;
      end
   end

   sipo_hold_reg #(
      .WIDTH (WIDTH)
   ) u_hold (
      .clk       (clk),
      .rst       (rst),
      .load      (load_c),
      .word      (shift_q),
      .ready     (par_ready),
      .par_out   (par_out),
      .par_valid (par_valid),
      .overrun   (overrun)
   );

   assign busy      = busy_q;
   assign frame_err = frame_err_q;

endmodule

// File: tb/tb_sipo_receiver.sv
// Bench for sipo_receiver: MSB-first and LSB-first instances on one line against a frame-level model.
module tb_sipo_receiver;

   localparam int unsigned W    = 8;
   localparam bit          IDLE = 1'b1;

   logic         clk = 1'b0;
   logic         rst;
   logic         ser_in;
   logic         ser_en;
   logic         par_ready;
   logic [W-1:0] par_out_m, par_out_l;
   logic         valid_m, valid_l, busy_m, busy_l, ferr_m, ferr_l, ovr_m, ovr_l;

   always #5 clk = ~clk;

   sipo_receiver #(.WIDTH(W), .MSB_FIRST(1'b1), .IDLE_LEVEL(IDLE)) dut_m (
      .clk(clk), .rst(rst), .ser_in(ser_in), .ser_en(ser_en),
      .par_out(par_out_m), .par_valid(valid_m), .par_ready(par_ready),
      .busy(busy_m), .frame_err(ferr_m), .overrun(ovr_m));

   sipo_receiver #(.WIDTH(W), .MSB_FIRST(1'b0), .IDLE_LEVEL(IDLE)) dut_l (
      .clk(clk), .rst(rst), .ser_in(ser_in), .ser_en(ser_en),
      .par_out(par_out_l), .par_valid(valid_l), .par_ready(par_ready),
      .busy(busy_l), .frame_err(ferr_l), .overrun(ovr_l));

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   // Model: phase 0 hunting, 1..W awaiting data bit, W+1 awaiting stop.
   int           phase;
   bit           q_bits[$];
   bit           ev;
   logic [W-1:0] ew_m, ew_l;
   bit           eferr, eovr;

   function automatic logic [W-1:0] word_of(input bit msb);
      logic [W-1:0] w;
      w = '0;
      for (int i = 0; i < int'(W); i++) begin
         if (msb) w[W-1-i] = q_bits[i];
         else     w[i]     = q_bits[i];
      end
      return w;
   endfunction

   task automatic model_reset();
      phase = 0;
      q_bits.delete();
      ev    = 1'b0;
      ew_m  = '0;
      ew_l  = '0;
      eferr = 1'b0;
      eovr  = 1'b0;
   endtask

   task automatic model_step(input bit en, input bit b, input bit rdy);
      bit good;
      good  = 1'b0;
      eferr = 1'b0;
      eovr  = 1'b0;
      if (en) begin
         if (phase == 0) begin
            if (b != IDLE) begin
               phase = 1;
               q_bits.delete();
            end
         end else if (phase <= int'(W)) begin
            q_bits.push_back(b);
            phase++;
         end else begin
            phase = 0;
            if (b == IDLE) good  = 1'b1;
            else           eferr = 1'b1;
         end
      end
      if (good) begin
         if (!ev || rdy) begin
            ew_m = word_of(1'b1);
            ew_l = word_of(1'b0);
            ev   = 1'b1;
         end else begin
            eovr = 1'b1;
         end
      end else if (ev && rdy) begin
         ev = 1'b0;
      end
   endtask

   task automatic check_all();
      check_eq("par_valid_m", valid_m, ev);
      check_eq("par_valid_l", valid_l, ev);
      check_eq("par_out_m", par_out_m, ew_m);
      check_eq("par_out_l", par_out_l, ew_l);
      check_eq("busy_m", busy_m, phase != 0);
      check_eq("busy_l", busy_l, phase != 0);
      check_eq("frame_err_m", ferr_m, eferr);
      check_eq("frame_err_l", ferr_l, eferr);
      check_eq("overrun_m", ovr_m, eovr);
      check_eq("overrun_l", ovr_l, eovr);
   endtask

   // One clock: drive, model on the edge, compare on the falling edge.
   task automatic cycle(input bit en, input bit b, input bit rdy);
      ser_en    = en;
      ser_in    = b;
      par_ready = rdy;
      @(posedge clk);
      model_step(en, b, rdy);
      @(negedge clk);
      check_all();
   endtask

   task automatic idle(input int n, input bit rdy);
      repeat (n) cycle(1'b1, IDLE, rdy);
   endtask

   // Sends the first n_line bits of a frame (data MSB first), gap dead cycles before each strobe.
   task automatic send_frame(input logic [W-1:0] word, input bit stop_ok, input int gap,
                             input bit rdy, input bit rdy_stop, input int n_line);
      bit line[W+2];
      line[0] = ~IDLE;
      for (int i = 0; i < int'(W); i++) line[i+1] = word[W-1-i];
      line[W+1] = stop_ok ? IDLE : ~IDLE;
      for (int i = 0; i < n_line; i++) begin
         repeat (gap) cycle(1'b0, 1'($urandom % 2), rdy);
         cycle(1'b1, line[i], (i == int'(W) + 1) ? rdy_stop : rdy);
      end
   endtask

   task automatic do_reset();
      #2 rst = 1'b1;
      #1;
      check_eq("rst_par_valid", valid_m, 0);
      check_eq("rst_par_out", par_out_m, 0);
      check_eq("rst_busy", busy_m, 0);
      check_eq("rst_frame_err", ferr_m, 0);
      check_eq("rst_overrun", ovr_m, 0);
      model_reset();
      @(negedge clk);
      rst = 1'b0;
   endtask

   initial begin
      rst       = 1'b1;
      ser_en    = 1'b0;
      ser_in    = IDLE;
      par_ready = 1'b0;
      model_reset();
      @(negedge clk);
      check_all();
      rst = 1'b0;

      // Basic good frame
      idle(2, 1'b1);
      send_frame(8'hAA, 1'b1, 0, 1'b1, 1'b1, W + 2);
      check_eq("t1_par_out", par_out_m, 8'hAA);
      check_eq("t1_par_out_lsb", par_out_l, 8'h55);
      check_eq("t1_valid", valid_m, 1);
      idle(1, 1'b1);
      check_eq("t1_drained", valid_m, 0);

      // Bad stop bit
      send_frame(8'hAA, 1'b0, 0, 1'b1, 1'b1, W + 2);
      check_eq("t2_frame_err", ferr_m, 1);
      check_eq("t2_valid", valid_m, 0);
      check_eq("t2_busy", busy_m, 0);
      idle(1, 1'b1);
      check_eq("t2_pulse_end", ferr_m, 0);

      // Overrun while consumer stalled
      send_frame(8'h3C, 1'b1, 0, 1'b0, 1'b0, W + 2);
      check_eq("t3_first", par_out_m, 8'h3C);
      send_frame(8'hC3, 1'b1, 0, 1'b0, 1'b0, W + 2);
      check_eq("t3_overrun", ovr_m, 1);
      check_eq("t3_held", par_out_m, 8'h3C);
      idle(1, 1'b0);
      idle(1, 1'b1);
      check_eq("t3_transfer", valid_m, 0);

      // Back-to-back frames, then accept coinciding with load
      send_frame(8'h01, 1'b1, 0, 1'b1, 1'b1, W + 2);
      check_eq("t4_lsb_first", par_out_l, 8'h80);
      send_frame(8'h80, 1'b1, 0, 1'b1, 1'b1, W + 2);
      check_eq("t4_second", par_out_m, 8'h80);
      idle(2, 1'b1);
      send_frame(8'h11, 1'b1, 0, 1'b0, 1'b0, W + 2);
      send_frame(8'h22, 1'b1, 0, 1'b0, 1'b1, W + 2);
      check_eq("t4_accept_load", par_out_m, 8'h22);
      check_eq("t4_accept_valid", valid_m, 1);
      check_eq("t4_accept_ovr", ovr_m, 0);
      idle(2, 1'b1);

      // Sparse strobes, then reset mid-frame
      send_frame(8'h5A, 1'b1, 2, 1'b1, 1'b1, W + 2);
      check_eq("t5_sparse", par_out_m, 8'h5A);
      idle(1, 1'b1);
      send_frame(8'hA5, 1'b1, 2, 1'b1, 1'b1, 5);
      check_eq("t5_busy", busy_m, 1);
      do_reset();
      send_frame(8'hFF, 1'b1, 0, 1'b1, 1'b1, W + 2);
      check_eq("t5_after_rst", par_out_m, 8'hFF);
      check_eq("t5_after_rst_v", valid_m, 1);

      // Randomized traffic
      for (int f = 0; f < 150; f++) begin
         logic [W-1:0] w;
         w = W'($urandom);
         send_frame(w, $urandom_range(0, 9) != 0, $urandom_range(0, 2),
                    1'($urandom % 2), 1'($urandom % 2),
                    (f % 37 == 36) ? int'($urandom_range(1, W + 1)) : int'(W + 2));
         if (f % 37 == 36) do_reset();
         repeat ($urandom_range(0, 3)) cycle(1'b1, IDLE, 1'($urandom % 2));
      end
      idle(3, 1'b1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
